// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with trap entry / trap return sequencing.
//
// Purpose
//   Holds the machine-mode CSRs and sequences trap entry and mret. A CSR access
//   returns the pre-update value one cycle later and applies the new value on
//   the same edge. Traps and returns run a short FSM
//   (IDLE -> TRAP_SAVE/RET -> REDIRECT) that ends in a one-cycle redirect pulse.
//
// Configuration
//   CSR_TRAP_COUNTERS_EN : when defined, implements the 64-bit mcycle/minstret
//                          counters (XLEN must be 32, counters are split into
//                          low/high halves). When undefined, the counter
//                          addresses read 0 and ignore writes, and no counter
//                          flops exist.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   csr_valid_i/op/addr   CSR access request (op: 00 rd, 01 wr, 10 set, 11 clr)
//   csr_wdata_i           write/set/clear operand
//   csr_rdata_o           registered old value of the addressed CSR
//   csr_illegal_o         registered one-cycle illegal-access flag
//   instret_i             one instruction retired this cycle
//   trap_i, trap_cause_i  trap entry request and mcause value (MSB = interrupt)
//   trap_pc_i             PC saved into mepc
//   mret_i                trap return request
//   redirect_o            one-cycle PC redirect pulse
//   redirect_pc_o         redirect target, valid with redirect_o
//   busy_o                FSM not in IDLE
module csr_trap_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            csr_valid_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            instret_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    // CSR addresses
    localparam logic [11:0] AddrMstatus    = 12'h300;
    localparam logic [11:0] AddrMisa       = 12'h301;
    localparam logic [11:0] AddrMie        = 12'h304;
    localparam logic [11:0] AddrMtvec      = 12'h305;
    localparam logic [11:0] AddrMcounteren = 12'h306;
    localparam logic [11:0] AddrMepc       = 12'h341;
    localparam logic [11:0] AddrMcause     = 12'h342;
    localparam logic [11:0] AddrMip        = 12'h344;
    localparam logic [11:0] AddrMcycle     = 12'hB00;
    localparam logic [11:0] AddrMinstret   = 12'hB02;
    localparam logic [11:0] AddrMcycleh    = 12'hB80;
    localparam logic [11:0] AddrMinstreth  = 12'hB82;
    localparam logic [11:0] AddrMvendorid  = 12'hF11;
    localparam logic [11:0] AddrMarchid    = 12'hF12;
    localparam logic [11:0] AddrMimpid     = 12'hF13;
    localparam logic [11:0] AddrMhartid    = 12'hF14;

    // Access operations
    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    // FSM states
    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StTrapSave = 2'd1;
    localparam logic [1:0] StRet      = 2'd2;
    localparam logic [1:0] StRedirect = 2'd3;

    logic [1:0]      state_q, state_d;

    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mip_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mcounteren_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:2] mepc_q;          // bits 1:0 always read as zero

    logic [XLEN-1:2] trap_pc_q;
    logic [XLEN-1:0] trap_cause_q;

    logic [XLEN-1:0] rdata_q;
    logic            illegal_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            accept;
    logic            mapped;
    logic            read_only;
    logic            wr_req;
    logic            illegal;
    logic            do_write;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] wmask;
    logic [XLEN-1:0] op_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] misa_val;
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    logic            we_mstatus, we_mie, we_mtvec, we_mcounteren;
    logic            we_mepc, we_mcause, we_mip;

`ifdef CSR_TRAP_COUNTERS_EN
    logic [63:0]     cyc_q, cyc_d;
    logic [63:0]     ins_q, ins_d;
    logic            we_mcycle, we_mcycleh, we_minstret, we_minstreth;
`else
    logic            unused_instret;
    assign unused_instret = instret_i;
`endif

    // CSR accesses only land while idle and lose to a simultaneous trap/mret.
    assign accept = (state_q == StIdle) && csr_valid_i && !trap_i && !mret_i;
    assign busy_o = (state_q != StIdle);

    always_comb begin
        misa_val = '0;
        misa_val[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
        misa_val[8] = 1'b1;

        mstatus_val = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7] = mstatus_mpie_q;
        mstatus_val[3] = mstatus_mie_q;
    end

    // Address decode: current value, writable-field mask and access class.
    always_comb begin
        old_val   = '0;
        wmask     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (csr_addr_i)
            AddrMisa:      begin old_val = misa_val; read_only = 1'b1; end
            AddrMvendorid: read_only = 1'b1;
            AddrMarchid:   read_only = 1'b1;
            AddrMimpid:    read_only = 1'b1;
            AddrMhartid:   begin old_val = HART_ID; read_only = 1'b1; end
            AddrMstatus: begin
                old_val  = mstatus_val;
                wmask[3] = 1'b1;
                wmask[7] = 1'b1;
            end
            AddrMie:        begin old_val = mie_q;        wmask = '1; end
            AddrMtvec:      begin old_val = mtvec_q;      wmask = '1; end
            AddrMcounteren: begin old_val = mcounteren_q; wmask = '1; end
            AddrMepc: begin
                old_val = {mepc_q, 2'b00};
                wmask = '1;
                wmask[1:0] = 2'b00;
            end
            AddrMcause: begin old_val = mcause_q; wmask = '1; end
            AddrMip:    begin old_val = mip_q;    wmask = '1; end
`ifdef CSR_TRAP_COUNTERS_EN
            AddrMcycle:    begin old_val[31:0] = cyc_q[31:0];  wmask = '1; end
            AddrMcycleh:   begin old_val[31:0] = cyc_q[63:32]; wmask = '1; end
            AddrMinstret:  begin old_val[31:0] = ins_q[31:0];  wmask = '1; end
            AddrMinstreth: begin old_val[31:0] = ins_q[63:32]; wmask = '1; end
`else
            // Counters absent: read 0, writes dropped silently (mask stays 0).
            AddrMcycle, AddrMcycleh, AddrMinstret, AddrMinstreth: ;
`endif
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        unique case (csr_op_i)
            OpWrite: op_val = csr_wdata_i;
            OpSet:   op_val = old_val | csr_wdata_i;
            OpClear: op_val = old_val & ~csr_wdata_i;
            default: op_val = old_val;
        endcase
        new_val = (op_val & wmask) | (old_val & ~wmask);
    end

    // Set/clear with a zero operand is a pure read and never a write.
    assign wr_req   = (csr_op_i == OpWrite) || (csr_op_i[1] && (|csr_wdata_i));
    assign illegal  = !mapped || (read_only && wr_req);
    assign do_write = accept && mapped && !read_only && wr_req;

    assign we_mstatus    = do_write && (csr_addr_i == AddrMstatus);
    assign we_mie        = do_write && (csr_addr_i == AddrMie);
    assign we_mtvec      = do_write && (csr_addr_i == AddrMtvec);
    assign we_mcounteren = do_write && (csr_addr_i == AddrMcounteren);
    assign we_mepc       = do_write && (csr_addr_i == AddrMepc);
    assign we_mcause     = do_write && (csr_addr_i == AddrMcause);
    assign we_mip        = do_write && (csr_addr_i == AddrMip);

    // Trap target: direct base, or base + 4*cause for vectored interrupts.
    always_comb begin
        trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
        trap_target = trap_base;
        if ((mtvec_q[1:0] == 2'b01) && trap_cause_q[XLEN-1]) begin
            trap_target = trap_base + {trap_cause_q[XLEN-3:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (trap_i) begin
                    state_d = StTrapSave;
                end else if (mret_i) begin
                    state_d = StRet;
                end
            end
            StTrapSave: state_d = StRedirect;
            StRet:      state_d = StRedirect;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RST;
            mcounteren_q   <= '0;
            mcause_q       <= '0;
            mepc_q         <= '0;
            trap_pc_q      <= '0;
            trap_cause_q   <= '0;
            rdata_q        <= '0;
            illegal_q      <= 1'b0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= accept && illegal;
            redirect_q <= (state_q == StRedirect);
            if (accept) begin
                rdata_q <= old_val;
            end

            if ((state_q == StIdle) && trap_i) begin
                trap_pc_q    <= trap_pc_i[XLEN-1:2];
                trap_cause_q <= trap_cause_i;
            end

            if (we_mstatus) begin
                mstatus_mie_q  <= new_val[3];
                mstatus_mpie_q <= new_val[7];
            end
            if (we_mie)        mie_q        <= new_val;
            if (we_mtvec)      mtvec_q      <= new_val;
            if (we_mcounteren) mcounteren_q <= new_val;
            if (we_mepc)       mepc_q       <= new_val[XLEN-1:2];
            if (we_mcause)     mcause_q     <= new_val;
            if (we_mip)        mip_q        <= new_val;

            // CSR writes are only accepted in IDLE, so these never collide.
            case (state_q)
                StTrapSave: begin
                    mepc_q         <= trap_pc_q;
                    mcause_q       <= trap_cause_q;
                    mstatus_mpie_q <= mstatus_mie_q;
                    mstatus_mie_q  <= 1'b0;
                    redirect_pc_q  <= trap_target;
                end
                StRet: begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                    redirect_pc_q  <= {mepc_q, 2'b00};
                end
                default: ;
            endcase
        end
    end

`ifdef CSR_TRAP_COUNTERS_EN
    assign we_mcycle    = do_write && (csr_addr_i == AddrMcycle);
    assign we_mcycleh   = do_write && (csr_addr_i == AddrMcycleh);
    assign we_minstret  = do_write && (csr_addr_i == AddrMinstret);
    assign we_minstreth = do_write && (csr_addr_i == AddrMinstreth);

    // A write to either half replaces the increment for the whole counter.
    always_comb begin
        cyc_d = cyc_q + 64'd1;
        ins_d = ins_q + {63'd0, instret_i};
        if (we_mcycle)    cyc_d = {cyc_q[63:32], new_val[31:0]};
        if (we_mcycleh)   cyc_d = {new_val[31:0], cyc_q[31:0]};
        if (we_minstret)  ins_d = {ins_q[63:32], new_val[31:0]};
        if (we_minstreth) ins_d = {new_val[31:0], ins_q[31:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end
`endif

    assign csr_rdata_o   = rdata_q;
    assign csr_illegal_o = illegal_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

endmodule
